// File: rtl/traffic_phase_scheduler.sv
// rtl/traffic_phase_scheduler.sv - demand-actuated four-way intersection phase scheduler
//
// Grants green to one approach at a time (N, S, E, W) from latched vehicle
// demand, with minimum/maximum green, yellow and all-red clearance, and
// emergency preemption. All timing is in ticks from an internal prescaler.
//
// Ports:
//   clk          system clock
//   rst_a        synchronous active-high reset
//   req[3:0]     vehicle detect per approach (bit0=N, bit1=S, bit2=E, bit3=W)
//   preempt      emergency preemption request (level)
//   preempt_dir  approach to preempt to, valid while preempt=1
//   green[3:0]   green lamp per approach
//   yellow[3:0]  yellow lamp per approach
//   red[3:0]     red lamp per approach
//   active_dir   approach currently owning the phase
//   phase        0=IDLE, 1=GREEN, 2=YELLOW, 3=ALLRED
//   tick         one-cycle timing pulse
module traffic_phase_scheduler #(
  parameter int TICK_DIV  = 50000000,
  parameter int MIN_GREEN = 4,
  parameter int MAX_GREEN = 8,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 1
) (
  input  logic       clk,
  input  logic       rst_a,
  input  logic [3:0] req,
  input  logic       preempt,
  input  logic [1:0] preempt_dir,
  output logic [3:0] green,
  output logic [3:0] yellow,
  output logic [3:0] red,
  output logic [1:0] active_dir,
  output logic [1:0] phase,
  output logic       tick
);

  localparam logic [1:0] PH_IDLE   = 2'd0;
  localparam logic [1:0] PH_GREEN  = 2'd1;
  localparam logic [1:0] PH_YELLOW = 2'd2;
  localparam logic [1:0] PH_ALLRED = 2'd3;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  localparam int TW = 16;
  localparam logic [TW-1:0] MIN_LAST = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] MAX_LAST = TW'(MAX_GREEN - 1);
  localparam logic [TW-1:0] YEL_LAST = TW'(YELLOW_T - 1);
  localparam logic [TW-1:0] ARD_LAST = TW'(ALLRED_T - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    pending_q, pending_d;
  logic [1:0]    phase_q, phase_d;
  logic [1:0]    dir_q, dir_d;

  logic          tick_w;
  logic [3:0]    set_mask;
  logic [3:0]    eff_pend;
  logic          has_win;
  logic [1:0]    win;
  logic          other;
  logic          grant;
  logic          end_green;

  assign tick_w     = (presc_q == PRE_LAST);
  assign tick       = tick_w;
  assign phase      = phase_q;
  assign active_dir = dir_q;

  // Demand of the approach already holding green is not latched; a same-cycle
  // request takes part in this cycle's winner evaluation via eff_pend.
  always_comb begin
    set_mask = req;
    if (phase_q == PH_GREEN) begin
      set_mask[dir_q] = 1'b0;
    end
    eff_pend = pending_q | set_mask;
  end

  // Round-robin search starts just after the current owner; scanning k from 4
  // down to 1 lets the nearest pending approach overwrite farther ones. k=4
  // wraps back to the owner itself, so it only wins when nothing else pends.
  always_comb begin
    logic [1:0] idx;
    idx     = 2'd0;
    has_win = 1'b0;
    win     = dir_q;
    if (preempt) begin
      has_win = 1'b1;
      win     = preempt_dir;
    end else begin
      for (int k = 4; k >= 1; k--) begin
        idx = dir_q + 2'(k);
        if (eff_pend[idx]) begin
          has_win = 1'b1;
          win     = idx;
        end
      end
    end
  end

  assign other = |(eff_pend & ~(4'b0001 << dir_q));

  // Green ends on preemption to another approach, or under competing demand
  // on gap-out (owner's detector idle past minimum) or max-out.
  always_comb begin
    end_green = 1'b0;
    if (preempt) begin
      end_green = (preempt_dir != dir_q);
    end else if (other) begin
      end_green = ((timer_q >= MIN_LAST) && !req[dir_q]) || (timer_q == MAX_LAST);
    end
  end

  always_comb begin
    presc_d   = tick_w ? '0 : presc_q + PW'(1);
    phase_d   = phase_q;
    dir_d     = dir_q;
    timer_d   = timer_q;
    pending_d = eff_pend;
    grant     = 1'b0;

    if (tick_w) begin
      case (phase_q)
        PH_IDLE: begin
          grant = has_win;
        end
        PH_GREEN: begin
          if (end_green) begin
            phase_d = PH_YELLOW;
            timer_d = '0;
          end else if (timer_q < MAX_LAST) begin
            timer_d = timer_q + TW'(1);
          end
        end
        PH_YELLOW: begin
          if (timer_q == YEL_LAST) begin
            phase_d = PH_ALLRED;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        default: begin
          if (timer_q == ARD_LAST) begin
            grant   = has_win;
            phase_d = PH_IDLE;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      endcase
    end

    if (grant) begin
      phase_d        = PH_GREEN;
      dir_d          = win;
      timer_d        = '0;
      pending_d[win] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_a) begin
      presc_q   <= '0;
      timer_q   <= '0;
      pending_q <= '0;
      phase_q   <= PH_IDLE;
      dir_q     <= 2'd3;
    end else begin
      presc_q   <= presc_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
      phase_q   <= phase_d;
      dir_q     <= dir_d;
    end
  end

  // Moore lamp decode: at most one approach is ever off red.
  always_comb begin
    green  = 4'b0000;
    yellow = 4'b0000;
    red    = 4'b1111;
    if (phase_q == PH_GREEN) begin
      green[dir_q] = 1'b1;
      red[dir_q]   = 1'b0;
    end else if (phase_q == PH_YELLOW) begin
      yellow[dir_q] = 1'b1;
      red[dir_q]    = 1'b0;
    end
  end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// tb/tb_traffic_phase_scheduler.sv - directed bench for traffic_phase_scheduler
module tb_traffic_phase_scheduler;

  logic       clk = 1'b0;
  logic       rst_a;
  logic [3:0] req;
  logic       preempt;
  logic [1:0] preempt_dir;
  logic [3:0] green, yellow, red;
  logic [1:0] active_dir, phase;
  logic       tick;

  int n_cmp = 0;
  int n_mis = 0;
  int n_viol = 0;

  traffic_phase_scheduler #(
    .TICK_DIV(4), .MIN_GREEN(4), .MAX_GREEN(8), .YELLOW_T(3), .ALLRED_T(1)
  ) dut (
    .clk(clk), .rst_a(rst_a), .req(req), .preempt(preempt),
    .preempt_dir(preempt_dir), .green(green), .yellow(yellow), .red(red),
    .active_dir(active_dir), .phase(phase), .tick(tick)
  );

  always #5 clk = ~clk;

  // Lamp exclusivity monitor, sampled away from the active edge.
  always @(negedge clk) begin
    int nonred;
    nonred = 0;
    for (int i = 0; i < 4; i++) begin
      if ((32'(green[i]) + 32'(yellow[i]) + 32'(red[i])) != 1) n_viol++;
      if (!red[i]) nonred++;
    end
    if (nonred > 1) n_viol++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance across the next transition edge (the edge ending a tick cycle).
  task automatic wait_tick_edge();
    int n;
    n = 0;
    while (tick !== 1'b1 && n < 16) begin
      step();
      n++;
    end
    if (tick !== 1'b1) check_eq("tick_timeout", 32'(tick), 32'd1);
    step();
  endtask

  task automatic count_phase(input logic [1:0] p, output int n);
    n = 0;
    while (phase === p && n < 400) begin
      step();
      n++;
    end
  endtask

  task automatic wait_phase(input logic [1:0] p, input int bound);
    int n;
    n = 0;
    while (phase !== p && n < bound) begin
      step();
      n++;
    end
    if (phase !== p) check_eq("phase_timeout", 32'(phase), 32'(p));
  endtask

  task automatic do_reset();
    rst_a = 1'b1;
    req = 4'b0000;
    preempt = 1'b0;
    preempt_dir = 2'd0;
    step();
    step();
    rst_a = 1'b0;
  endtask

  initial begin
    logic [7:0] pat8;
    logic [3:0] pat4;
    int n;

    // Reset state and idle prescaler
    do_reset();
    check_eq("rst_phase", 32'(phase), 32'd0);
    check_eq("rst_red", 32'(red), 32'hF);
    check_eq("rst_green", 32'(green), 32'h0);
    check_eq("rst_yellow", 32'(yellow), 32'h0);
    check_eq("rst_dir", 32'(active_dir), 32'd3);
    check_eq("rst_tick", 32'(tick), 32'd0);
    for (int i = 0; i < 8; i++) begin
      step();
      pat8[i] = tick;
    end
    check_eq("tick_pattern", 32'(pat8), 32'h44);
    wait_tick_edge();
    wait_tick_edge();
    check_eq("idle_stays", 32'(phase), 32'd0);
    check_eq("idle_red", 32'(red), 32'hF);

    // Single N pulse, N rests in green with no other demand
    req = 4'b0001;
    step();
    req = 4'b0000;
    wait_tick_edge();
    check_eq("n_grant_phase", 32'(phase), 32'd1);
    check_eq("n_grant_green", 32'(green), 32'h1);
    check_eq("n_grant_red", 32'(red), 32'hE);
    check_eq("n_grant_dir", 32'(active_dir), 32'd0);
    for (int i = 0; i < 20; i++) wait_tick_edge();
    check_eq("n_rest_phase", 32'(phase), 32'd1);
    check_eq("n_rest_green", 32'(green), 32'h1);

    // Max-out: N held, E pulsed
    do_reset();
    req = 4'b0101;
    step();
    req = 4'b0001;
    wait_tick_edge();
    check_eq("mx_n_green", 32'(green), 32'h1);
    for (int i = 0; i < 7; i++) wait_tick_edge();
    check_eq("mx_before_max", 32'(phase), 32'd1);
    wait_tick_edge();
    check_eq("mx_yellow_phase", 32'(phase), 32'd2);
    check_eq("mx_yellow_lamp", 32'(yellow), 32'h1);
    count_phase(2'd2, n);
    check_eq("mx_yellow_cycles", 32'(n), 32'd12);
    check_eq("mx_allred_phase", 32'(phase), 32'd3);
    check_eq("mx_allred_red", 32'(red), 32'hF);
    count_phase(2'd3, n);
    check_eq("mx_allred_cycles", 32'(n), 32'd4);
    check_eq("mx_e_phase", 32'(phase), 32'd1);
    check_eq("mx_e_dir", 32'(active_dir), 32'd2);
    check_eq("mx_e_green", 32'(green), 32'h4);
    req = 4'b0000;

    // Gap-out with S and W pending, round-robin S before W
    do_reset();
    req = 4'b0001;
    step();
    req = 4'b0000;
    wait_tick_edge();
    check_eq("go_n_dir", 32'(active_dir), 32'd0);
    req = 4'b1010;
    step();
    req = 4'b0000;
    count_phase(2'd1, n);
    check_eq("go_n_green_cycles", 32'(n), 32'd15);
    check_eq("go_n_yellow", 32'(yellow), 32'h1);
    wait_phase(2'd1, 80);
    check_eq("go_s_dir", 32'(active_dir), 32'd1);
    check_eq("go_s_green", 32'(green), 32'h2);
    count_phase(2'd1, n);
    check_eq("go_s_green_cycles", 32'(n), 32'd16);
    wait_phase(2'd1, 80);
    check_eq("go_w_dir", 32'(active_dir), 32'd3);
    check_eq("go_w_green", 32'(green), 32'h8);

    // Preemption from E to W, held past max with N pending
    do_reset();
    req = 4'b0100;
    step();
    req = 4'b0000;
    wait_tick_edge();
    check_eq("pe_e_dir", 32'(active_dir), 32'd2);
    wait_tick_edge();
    preempt = 1'b1;
    preempt_dir = 2'd3;
    req = 4'b0001;
    step();
    req = 4'b0000;
    wait_tick_edge();
    check_eq("pe_e_yellow_phase", 32'(phase), 32'd2);
    check_eq("pe_e_yellow_lamp", 32'(yellow), 32'h4);
    count_phase(2'd2, n);
    check_eq("pe_yellow_cycles", 32'(n), 32'd12);
    count_phase(2'd3, n);
    check_eq("pe_allred_cycles", 32'(n), 32'd4);
    check_eq("pe_w_dir", 32'(active_dir), 32'd3);
    check_eq("pe_w_green", 32'(green), 32'h8);
    for (int i = 0; i < 12; i++) wait_tick_edge();
    check_eq("pe_w_held_phase", 32'(phase), 32'd1);
    check_eq("pe_w_held_dir", 32'(active_dir), 32'd3);
    preempt = 1'b0;
    wait_tick_edge();
    check_eq("pe_release_yellow", 32'(yellow), 32'h8);

    // Reset during yellow
    rst_a = 1'b1;
    step();
    check_eq("ry_phase", 32'(phase), 32'd0);
    check_eq("ry_red", 32'(red), 32'hF);
    check_eq("ry_yellow", 32'(yellow), 32'h0);
    check_eq("ry_dir", 32'(active_dir), 32'd3);
    rst_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      pat4[i] = tick;
    end
    check_eq("ry_tick_restart", 32'(pat4), 32'h4);
    wait_tick_edge();
    wait_tick_edge();
    check_eq("ry_pending_cleared", 32'(phase), 32'd0);

    check_eq("lamp_invariant", 32'(n_viol), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
